// File: rtl/multi_debouncer.sv
// rtl/multi_debouncer.sv - multi-channel debouncer with rise/fall pulses; optional long-press hold via MULTI_DEBOUNCER_HOLD_EN
module multi_debouncer #(
    parameter int   CHANNELS      = 4,
    parameter int   STABLE_CYCLES = 16,
    parameter logic INIT_LEVEL    = 1'b0,
    parameter int   HOLD_CYCLES   = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] hold
);

    localparam int CNT_W = ($clog2(STABLE_CYCLES) > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    // Reject illegal configurations at elaboration time
    if (CHANNELS < 1 || STABLE_CYCLES < 2 || HOLD_CYCLES <= STABLE_CYCLES) begin : g_bad_params
        $error("multi_debouncer: illegal parameter combination");
    end

    logic [CHANNELS-1:0] s1;
    logic [CHANNELS-1:0] s2;
    logic [CNT_W-1:0]    cnt [CHANNELS];

    // Two-flop synchroniser per channel; only s2 is used downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= {CHANNELS{INIT_LEVEL}};
            s2 <= {CHANNELS{INIT_LEVEL}};
        end else begin
            s1 <= in;
            s2 <= s1;
        end
    end

    // Qualify each channel: a level must differ from out for STABLE_CYCLES consecutive cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out  <= {CHANNELS{INIT_LEVEL}};
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (s2[i] == out[i]) begin
                    // Any agreeing cycle restarts qualification, which is what rejects bounces
                    cnt[i]  <= '0;
                    rise[i] <= 1'b0;
                    fall[i] <= 1'b0;
                end else if (cnt[i] != CNT_MAX) begin
                    cnt[i]  <= cnt[i] + 1'b1;
                    rise[i] <= 1'b0;
                    fall[i] <= 1'b0;
                end else begin
                    out[i]  <= s2[i];
                    cnt[i]  <= '0;
                    rise[i] <= s2[i];
                    fall[i] <= ~s2[i];
                end
            end
        end
    end

`ifdef MULTI_DEBOUNCER_HOLD_EN
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    logic [HOLD_W-1:0] hcnt [CHANNELS];

    // Count high-time per channel, saturating so the long-press pulse fires once per press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                hcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (out[i]) begin
                    if (hcnt[i] != HOLD_MAX) begin
                        hcnt[i] <= hcnt[i] + 1'b1;
                    end
                    hold[i] <= (hcnt[i] == HOLD_MAX - 1'b1);
                end else begin
                    hcnt[i] <= '0;
                    hold[i] <= 1'b0;
                end
            end
        end
    end
`else
    // Long-press detection not built; the port stays for a uniform interface
    assign hold = '0;
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// tb/tb_multi_debouncer.sv - randomized and directed bench for multi_debouncer against a window-based model
module tb_multi_debouncer;

    localparam int   CH     = 4;
    localparam int   STABLE = 8;
    localparam logic INIT   = 1'b0;
    localparam int   HOLDC  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CH-1:0] din = '0;
    logic [CH-1:0] out;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] hold;

    int checks   = 0;
    int failures = 0;

    multi_debouncer #(
        .CHANNELS      (CH),
        .STABLE_CYCLES (STABLE),
        .INIT_LEVEL    (INIT),
        .HOLD_CYCLES   (HOLDC)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .in   (din),
        .out  (out),
        .rise (rise),
        .fall (fall),
        .hold (hold)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: out flips when the input seen two samples ago, and the
    // STABLE-1 samples before it, all disagree with the current out.
    logic [CH-1:0] samp [$];
    logic [CH-1:0] m_out, m_rise, m_fall, m_hold, m_prev;
    int            edge_no = 0;
    int            rise_edge [CH];
    logic          flip;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_out  = {CH{INIT}};
            m_rise = '0;
            m_fall = '0;
            m_hold = '0;
            samp.delete();
            for (int k = 0; k < STABLE + 3; k++) samp.push_back({CH{INIT}});
        end else begin
            edge_no++;
            m_prev = m_out;
            samp.push_back(din);
            m_rise = '0;
            m_fall = '0;
            m_hold = '0;
            for (int c = 0; c < CH; c++) begin
                flip = 1'b1;
                for (int j = 0; j < STABLE; j++) begin
                    if (samp[samp.size() - 3 - j][c] == m_prev[c]) flip = 1'b0;
                end
                if (flip) begin
                    m_out[c]  = ~m_prev[c];
                    m_rise[c] = ~m_prev[c];
                    m_fall[c] = m_prev[c];
                    if (!m_prev[c]) rise_edge[c] = edge_no;
                end
`ifdef MULTI_DEBOUNCER_HOLD_EN
                if (m_prev[c] && (edge_no - rise_edge[c] == HOLDC)) m_hold[c] = 1'b1;
`endif
            end
            while (samp.size() > STABLE + 3) void'(samp.pop_front());
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        chk("out",  32'(out),  32'(m_out));
        chk("rise", 32'(rise), 32'(m_rise));
        chk("fall", 32'(fall), 32'(m_fall));
        chk("hold", 32'(hold), 32'(m_hold));
        chk("rise_fall_excl", 32'(rise & fall), 32'd0);
    end

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1 rst = 1'b1;
        ticks(3);
        rst = 1'b0;
        din = 4'b0000;
        ticks(20);
        chk("idle_out", 32'(out), 32'd0);

        // Clean step on channel 0
        din[0] = 1'b1;
        ticks(9);
        chk("step0_before", 32'(out[0]), 32'd0);
        ticks(1);
        chk("step0_out", 32'(out[0]), 32'd1);
        chk("step0_rise", 32'(rise[0]), 32'd1);
        ticks(1);
        chk("step0_rise_end", 32'(rise[0]), 32'd0);

        // Channel 1 bouncing every 3 cycles, then settling high
        for (int s = 0; s < 16; s++) begin
            din[1] = (s % 2 == 0);
            ticks(3);
            chk("bounce1_out", 32'(out[1]), 32'd0);
        end
        din[1] = 1'b1;
        ticks(9);
        chk("settle1_before", 32'(out[1]), 32'd0);
        ticks(1);
        chk("settle1_rise", 32'(rise[1]), 32'd1);

        // Channel 2: 7 high, 1 low glitch, then high
        din[2] = 1'b1;
        ticks(7);
        din[2] = 1'b0;
        ticks(1);
        din[2] = 1'b1;
        ticks(9);
        chk("glitch2_before", 32'(out[2]), 32'd0);
        ticks(1);
        chk("glitch2_rise", 32'(rise[2]), 32'd1);

        // All channels together
        din = 4'b0000;
        ticks(15);
        din = 4'b1111;
        ticks(9);
        chk("all_rise_before", 32'(rise), 32'd0);
        ticks(1);
        chk("all_rise", 32'(rise), 32'hf);
        ticks(10);
        din = 4'b0000;
        ticks(9);
        chk("all_fall_before", 32'(fall), 32'd0);
        ticks(1);
        chk("all_fall", 32'(fall), 32'hf);

        // Mid-operation reset with input held high through release
        din = 4'b1111;
        ticks(10);
        chk("pre_rst_out", 32'(out), 32'hf);
        ticks(3);
        din = 4'b0000;
        ticks(4);
        #2 rst = 1'b1;
        #1;
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_pulses", 32'({rise, fall, hold}), 32'd0);
        din = 4'b1111;
        ticks(3);
        rst = 1'b0;
        ticks(9);
        chk("rel_before", 32'(out), 32'd0);
        ticks(1);
        chk("rel_rise", 32'(rise), 32'hf);

        // Randomized bouncing, with an occasional asynchronous reset
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 11) == 0) din[c] = ~din[c];
            end
            if ($urandom_range(0, 799) == 0) begin
                #2 rst = 1'b1;
                ticks(2);
                rst = 1'b0;
            end
            ticks(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
